// File: rtl/tcm_boot_loader_if.sv
// -----------------------------------------------------------------------------
// tcm_boot_loader_if
//
// Host word stream into the TCM boot loader.
//
// Handshake: a beat transfers on a rising clock edge when s_valid and s_ready
// are both high. The host holds s_data/s_sel/s_boot stable while s_valid is
// high and the beat has not transferred. s_ready may rise or fall without
// regard to s_valid.
//
// Signals:
//   s_valid  host -> loader  beat valid
//   s_ready  loader -> host  loader accepts a beat this cycle
//   s_data   host -> loader  32-bit word, byte 0 in s_data[7:0]
//   s_sel    host -> loader  target: 0 = ITCM, 1 = DTCM
//   s_boot   host -> loader  beat is a boot command (s_data/s_sel ignored)
//
// Modports:
//   master  host side
//   slave   loader side
// -----------------------------------------------------------------------------
interface tcm_boot_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_sel;
  logic        s_boot;

  modport master (
    output s_valid,
    output s_data,
    output s_sel,
    output s_boot,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_sel,
    input  s_boot,
    output s_ready
  );
endinterface

// File: rtl/tcm_boot_loader.sv
// -----------------------------------------------------------------------------
// tcm_boot_loader
//
// Loads program and data words from a host stream into the core's TCMs and
// then boots the core. Each 32-bit word is written as four byte writes,
// little-endian, on consecutive cycles. The core is held in reset while
// loading. A boot beat releases the core reset, and one cycle later raises
// cpu_start. A word that would run past the end of its TCM is dropped. That
// sets a sticky error and parks the loader, which keeps the core in reset and
// drains the host, until rst_.
//
// Ports:
//   clk        clock
//   rst_       asynchronous active-low reset
//   host       host word stream (tcm_boot_loader_if.slave)
//   itcm_en    ITCM byte-write enable     (registered)
//   itcm_addr  ITCM byte address          (registered)
//   itcm_data  ITCM byte data             (registered)
//   dtcm_en    DTCM byte-write enable     (registered)
//   dtcm_addr  DTCM byte address          (registered)
//   dtcm_data  DTCM byte data             (registered)
//   cpu_rst_   core reset, active-low     (registered)
//   cpu_start  core start                 (registered)
//   busy       a word is being serialised
//   error      sticky overflow flag
//   state_dbg  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module tcm_boot_loader #(
  parameter int     PC_SIZE    = 32,
  parameter int     DATA_SIZE  = 32,
  parameter longint ITCM_BYTES = 1024,
  parameter longint DTCM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_,
  tcm_boot_loader_if.slave     host,
  output logic                 itcm_en,
  output logic [PC_SIZE-1:0]   itcm_addr,
  output logic [7:0]           itcm_data,
  output logic                 dtcm_en,
  output logic [DATA_SIZE-1:0] dtcm_addr,
  output logic [7:0]           dtcm_data,
  output logic                 cpu_rst_,
  output logic                 cpu_start,
  output logic                 busy,
  output logic                 error,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SER  = 3'd1,
    ST_REL  = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // The pointers carry one extra bit so that a completely full TCM
  // (pointer == capacity == 2^SIZE) can be represented without wrapping.
  localparam int IW = PC_SIZE + 1;
  localparam int DW = DATA_SIZE + 1;

  localparam logic [IW-1:0] I_LIMIT = IW'(ITCM_BYTES);
  localparam logic [DW-1:0] D_LIMIT = DW'(DTCM_BYTES);
  localparam logic [IW-1:0] I_STEP  = IW'(4);
  localparam logic [DW-1:0] D_STEP  = DW'(4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [31:0]         word_q,   word_d;
  logic                sel_q,    sel_d;
  logic [1:0]          idx_q,    idx_d;
  logic [IW-1:0]       iptr_q,   iptr_d;
  logic [DW-1:0]       dptr_q,   dptr_d;
  logic                error_q,  error_d;

  logic                itcm_en_q,   itcm_en_d;
  logic [PC_SIZE-1:0]  itcm_addr_q, itcm_addr_d;
  logic [7:0]          itcm_data_q, itcm_data_d;
  logic                dtcm_en_q,   dtcm_en_d;
  logic [DATA_SIZE-1:0] dtcm_addr_q, dtcm_addr_d;
  logic [7:0]          dtcm_data_q, dtcm_data_d;
  logic                core_rel_q,  core_rel_d;
  logic                start_q,     start_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic ready;
  logic accept;
  logic last_byte;

  assign last_byte = (state_q == ST_SER) && (idx_q == 2'd3);

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_SER:  ready = last_byte;      // overlap the next word with byte 3
      ST_ERR:  ready = 1'b1;           // keep draining the host after an overflow
      ST_REL,
      ST_RUN:  ready = 1'b0;
      default: ready = 1'b0;
    endcase
  end

  assign host.s_ready = ready;
  assign accept       = host.s_valid & ready;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  logic        take_beat;   // this cycle may start a new word or boot
  logic        emit;        // drive a byte write on the next cycle
  logic [31:0] emit_word;
  logic        emit_sel;
  logic [1:0]  emit_idx;
  logic [7:0]  emit_byte;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    iptr_d      = iptr_q;
    dptr_d      = dptr_q;
    error_d     = error_q;
    take_beat   = 1'b0;
    emit        = 1'b0;
    emit_word   = word_q;
    emit_sel    = sel_q;
    emit_idx    = idx_q;
    emit_byte   = 8'd0;
    itcm_en_d   = 1'b0;
    itcm_addr_d = '0;
    itcm_data_d = 8'd0;
    dtcm_en_d   = 1'b0;
    dtcm_addr_d = '0;
    dtcm_data_d = 8'd0;
    // The core sees reset released from REL onwards and start from RUN
    // onwards, each one register stage after the state is entered.
    core_rel_d  = (state_q == ST_REL) || (state_q == ST_RUN);
    start_d     = (state_q == ST_RUN);

    unique case (state_q)
      ST_IDLE: take_beat = 1'b1;
      ST_SER: begin
        if (last_byte) begin
          // Word complete: retire it, then possibly chain the next beat.
          take_beat = 1'b1;
          state_d   = ST_IDLE;
          if (sel_q) dptr_d = dptr_q + D_STEP;
          else       iptr_d = iptr_q + I_STEP;
        end else begin
          idx_d    = idx_q + 2'd1;
          emit     = 1'b1;
          emit_idx = idx_q + 2'd1;
        end
      end
      ST_REL:  state_d = ST_RUN;
      ST_RUN,
      ST_ERR:  state_d = state_q;
      default: state_d = ST_IDLE;
    endcase

    // New beat. The overflow check uses the pointer after the word that is
    // finishing on this edge has been retired.
    if (take_beat && accept) begin
      if (host.s_boot) begin
        state_d = ST_REL;
      end else if (host.s_sel ? ((dptr_d + D_STEP) > D_LIMIT)
                              : ((iptr_d + I_STEP) > I_LIMIT)) begin
        error_d = 1'b1;
        state_d = ST_ERR;
      end else begin
        word_d    = host.s_data;
        sel_d     = host.s_sel;
        idx_d     = 2'd0;
        state_d   = ST_SER;
        emit      = 1'b1;
        emit_word = host.s_data;
        emit_sel  = host.s_sel;
        emit_idx  = 2'd0;
      end
    end

    emit_byte = emit_word[{emit_idx, 3'b000} +: 8];

    // iptr_d/dptr_d hold the base of the word being written in every case:
    // unchanged mid-word, freshly advanced when a chained word starts.
    if (emit && !emit_sel) begin
      itcm_en_d   = 1'b1;
      itcm_addr_d = iptr_d[PC_SIZE-1:0] + PC_SIZE'(emit_idx);
      itcm_data_d = emit_byte;
    end
    if (emit && emit_sel) begin
      dtcm_en_d   = 1'b1;
      dtcm_addr_d = dptr_d[DATA_SIZE-1:0] + DATA_SIZE'(emit_idx);
      dtcm_data_d = emit_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      word_q      <= 32'd0;
      sel_q       <= 1'b0;
      idx_q       <= 2'd0;
      iptr_q      <= '0;
      dptr_q      <= '0;
      error_q     <= 1'b0;
      itcm_en_q   <= 1'b0;
      itcm_addr_q <= '0;
      itcm_data_q <= 8'd0;
      dtcm_en_q   <= 1'b0;
      dtcm_addr_q <= '0;
      dtcm_data_q <= 8'd0;
      core_rel_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      iptr_q      <= iptr_d;
      dptr_q      <= dptr_d;
      error_q     <= error_d;
      itcm_en_q   <= itcm_en_d;
      itcm_addr_q <= itcm_addr_d;
      itcm_data_q <= itcm_data_d;
      dtcm_en_q   <= dtcm_en_d;
      dtcm_addr_q <= dtcm_addr_d;
      dtcm_data_q <= dtcm_data_d;
      core_rel_q  <= core_rel_d;
      start_q     <= start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign itcm_en   = itcm_en_q;
  assign itcm_addr = itcm_addr_q;
  assign itcm_data = itcm_data_q;
  assign dtcm_en   = dtcm_en_q;
  assign dtcm_addr = dtcm_addr_q;
  assign dtcm_data = dtcm_data_q;
  assign cpu_rst_  = core_rel_q;
  assign cpu_start = start_q;
  assign busy      = (state_q == ST_SER);
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_tcm_boot_loader
//
// Bench for tcm_boot_loader. Instance "a" uses 1 KiB TCMs. Instance "b" uses
// 8-byte TCMs, which makes overflow reachable.
// -----------------------------------------------------------------------------
module tb_tcm_boot_loader;

  localparam int A_ITCM = 1024;
  localparam int A_DTCM = 1024;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  tcm_boot_loader_if hif ();
  tcm_boot_loader_if bif ();

  logic        itcm_en, dtcm_en, cpu_rst_, cpu_start, busy, error;
  logic [31:0] itcm_addr, dtcm_addr;
  logic [7:0]  itcm_data, dtcm_data;
  logic [2:0]  state_dbg;

  logic        b_itcm_en, b_dtcm_en, b_cpu_rst_, b_cpu_start, b_busy, b_error;
  logic [31:0] b_itcm_addr, b_dtcm_addr;
  logic [7:0]  b_itcm_data, b_dtcm_data;
  logic [2:0]  b_state_dbg;

  tcm_boot_loader #(
    .PC_SIZE(32), .DATA_SIZE(32), .ITCM_BYTES(A_ITCM), .DTCM_BYTES(A_DTCM)
  ) dut_a (
    .clk(clk), .rst_(rst_), .host(hif),
    .itcm_en(itcm_en), .itcm_addr(itcm_addr), .itcm_data(itcm_data),
    .dtcm_en(dtcm_en), .dtcm_addr(dtcm_addr), .dtcm_data(dtcm_data),
    .cpu_rst_(cpu_rst_), .cpu_start(cpu_start), .busy(busy), .error(error),
    .state_dbg(state_dbg)
  );

  tcm_boot_loader #(
    .PC_SIZE(32), .DATA_SIZE(32), .ITCM_BYTES(8), .DTCM_BYTES(8)
  ) dut_b (
    .clk(clk), .rst_(rst_), .host(bif),
    .itcm_en(b_itcm_en), .itcm_addr(b_itcm_addr), .itcm_data(b_itcm_data),
    .dtcm_en(b_dtcm_en), .dtcm_addr(b_dtcm_addr), .dtcm_data(b_dtcm_data),
    .cpu_rst_(b_cpu_rst_), .cpu_start(b_cpu_start), .busy(b_busy), .error(b_error),
    .state_dbg(b_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];    // expected byte writes on instance a
  wr_t exp_qb[$];   // expected byte writes on instance b

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: next free byte per TCM, and whether loading has stopped
  // (boot or overflow). It works on whole words.
  logic [31:0] m_ptr [2];
  bit          m_stop;

  function automatic void model_clear();
    m_ptr[0] = 32'd0;
    m_ptr[1] = 32'd0;
    m_stop   = 1'b0;
    exp_q.delete();
    exp_qb.delete();
  endfunction

  function automatic void model_accept(input logic sel, input logic [31:0] d, input logic boot,
                                       input bit use_tab, input logic [31:0] t_base,
                                       input logic [31:0] t_bytes);
    wr_t         w;
    logic [31:0] lim;
    if (m_stop) return;
    if (boot) begin
      m_stop = 1'b1;
      return;
    end
    lim = sel ? 32'(A_DTCM) : 32'(A_ITCM);
    if (m_ptr[sel] + 32'd4 > lim) begin
      m_stop = 1'b1;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      w.is_d = sel;
      if (use_tab) begin
        w.addr = t_base + 32'(k);
        w.data = t_bytes[31 - 8*k -: 8];
      end else begin
        w.addr = m_ptr[sel] + 32'(k);
        w.data = 8'(d >> (8*k));
      end
      exp_q.push_back(w);
    end
    m_ptr[sel] = m_ptr[sel] + 32'd4;
  endfunction

  // Write monitors: every byte write must be the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (rst_) begin
      check("a_busy_vs_write", 64'(busy), 64'(itcm_en | dtcm_en));
      check("a_one_port", 64'(itcm_en & dtcm_en), 64'd0);
      if (itcm_en | dtcm_en) begin
        if (exp_q.size() == 0) begin
          check("a_unexpected_write", 64'(dtcm_en ? dtcm_addr : itcm_addr), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("a_wr_port", 64'(dtcm_en), 64'(e.is_d));
          check("a_wr_addr", 64'(dtcm_en ? dtcm_addr : itcm_addr), 64'(e.addr));
          check("a_wr_data", 64'(dtcm_en ? dtcm_data : itcm_data), 64'(e.data));
        end
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (rst_ && (b_itcm_en | b_dtcm_en)) begin
      if (exp_qb.size() == 0) begin
        check("b_unexpected_write", 64'(b_itcm_addr), 64'hFFFF_FFFF);
      end else begin
        e = exp_qb.pop_front();
        check("b_wr_port", 64'(b_dtcm_en), 64'(e.is_d));
        check("b_wr_addr", 64'(b_itcm_addr), 64'(e.addr));
        check("b_wr_data", 64'(b_itcm_data), 64'(e.data));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    hif.s_valid = 1'b0; hif.s_boot = 1'b0;
    bif.s_valid = 1'b0; bif.s_boot = 1'b0;
    rst_ = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present one beat on a; returns 1 ns after the edge that accepted it.
  task automatic send_a(input logic sel, input logic [31:0] d, input logic boot, input bit hold,
                        input bit use_tab, input logic [31:0] t_base, input logic [31:0] t_bytes);
    int n = 0;
    hif.s_valid = 1'b1;
    hif.s_sel   = sel;
    hif.s_data  = d;
    hif.s_boot  = boot;
    @(negedge clk);
    while (!hif.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hif.s_ready) begin
      check("a_send_timeout", 64'(n), 64'd0);
      hif.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(sel, d, boot, use_tab, t_base, t_bytes);
    #1;
    if (!hold) hif.s_valid = 1'b0;
  endtask

  task automatic send_b(input logic sel, input logic [31:0] d, input logic boot, input bit hold);
    int n = 0;
    bif.s_valid = 1'b1;
    bif.s_sel   = sel;
    bif.s_data  = d;
    bif.s_boot  = boot;
    @(negedge clk);
    while (!bif.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bif.s_ready) begin
      check("b_send_timeout", 64'(n), 64'd0);
      bif.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) bif.s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after the edge E that accepted a boot beat on a.
  task automatic check_boot_a(input string tag);
    int bad = 0;
    check({tag, "_rst_at_E"},   64'(cpu_rst_), 64'd0);
    check({tag, "_start_at_E"}, 64'(cpu_start), 64'd0);
    check({tag, "_en_at_E"},    64'(itcm_en | dtcm_en), 64'd0);
    @(posedge clk); #1;
    check({tag, "_rst_at_E1"},   64'(cpu_rst_), 64'd1);
    check({tag, "_start_at_E1"}, 64'(cpu_start), 64'd0);
    check({tag, "_en_at_E1"},    64'(itcm_en | dtcm_en), 64'd0);
    @(posedge clk); #1;
    check({tag, "_start_at_E2"}, 64'(cpu_start), 64'd1);
    check({tag, "_ready_off"},   64'(hif.s_ready), 64'd0);
    hif.s_valid = 1'b1;
    hif.s_boot  = 1'b0;
    hif.s_sel   = 1'($urandom_range(0, 1));
    hif.s_data  = $urandom;
    repeat (8) begin
      @(negedge clk);
      if (hif.s_ready || itcm_en || dtcm_en || !cpu_start || !cpu_rst_) bad++;
    end
    check({tag, "_run_quiet"}, 64'(bad), 64'd0);
    hif.s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_a_zero"}, 64'(|{itcm_en, itcm_addr, itcm_data, dtcm_en, dtcm_addr, dtcm_data,
                                   cpu_rst_, cpu_start, busy, error}), 64'd0);
    check({tag, "_a_ready"}, 64'(hif.s_ready), 64'd1);
    check({tag, "_b_zero"}, 64'(|{b_itcm_en, b_itcm_addr, b_itcm_data, b_dtcm_en, b_dtcm_addr,
                                   b_dtcm_data, b_cpu_rst_, b_cpu_start, b_busy, b_error}), 64'd0);
    check({tag, "_b_ready"}, 64'(bif.s_ready), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        sel;
    logic [31:0] word;
    logic [31:0] exp_base;
    logic [31:0] exp_bytes;   // bytes in write order: [31:24] first, [7:0] last
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] b_exp[8];

  initial begin
    int  ni, nd, bad;
    bit  hold;
    wr_t w;

    vecs[0] = '{1'b0, 32'h0010_0093, 32'd0, 32'h93_00_10_00};
    vecs[1] = '{1'b0, 32'hDEAD_BEEF, 32'd4, 32'hEF_BE_AD_DE};
    vecs[2] = '{1'b1, 32'h0000_0001, 32'd0, 32'h01_00_00_00};
    vecs[3] = '{1'b1, 32'hFFFF_FF03, 32'd4, 32'h03_FF_FF_FF};
    vecs[4] = '{1'b0, 32'h1234_5678, 32'd8, 32'h78_56_34_12};
    b_exp   = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

    hif.s_valid = 1'b0; hif.s_data = 32'd0; hif.s_sel = 1'b0; hif.s_boot = 1'b0;
    bif.s_valid = 1'b0; bif.s_data = 32'd0; bif.s_sel = 1'b0; bif.s_boot = 1'b0;
    rst_ = 1'b1;
    model_clear();
    #2 rst_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // Directed words: single ITCM word timing, then ITCM/DTCM interleave.
    for (int i = 0; i < 5; i++) begin
      send_a(vecs[i].sel, vecs[i].word, 1'b0, 1'b0, 1'b1, vecs[i].exp_base, vecs[i].exp_bytes);
      if (i == 0) begin
        ni = 0; nd = 0;
        for (int c = 0; c < 6; c++) begin
          ni += int'(itcm_en);
          nd += int'(dtcm_en);
          @(posedge clk); #1;
        end
        check("single_itcm_en_cycles", 64'(ni), 64'd4);
        check("single_dtcm_quiet", 64'(nd), 64'd0);
      end
    end
    wait_drain("table_drain");

    // Boot from IDLE after loading.
    send_a(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check_boot_a("boot_idle");

    // Boot with nothing loaded; s_sel set alongside s_boot.
    do_reset();
    send_a(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check_boot_a("boot_empty");

    // Reset in the middle of a word.
    do_reset();
    send_a(1'b0, 32'hA1B2_C3D4, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);   // byte 1 is on the port here
    #1;
    rst_ = 1'b0;
    #1;
    check_reset_outs("midrst");
    model_clear();
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk); #1;
    send_a(1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0D_F0_AD_0B);
    wait_drain("midrst_drain");

    // Six ITCM words with s_valid held high.
    do_reset();
    fork
      begin
        for (int k = 0; k < 6; k++)
          send_a(1'b0, $urandom, 1'b0, k < 5, 1'b0, 32'd0, 32'd0);
      end
      begin
        int t = 0, run = 0, badr = 0;
        @(negedge clk);
        while (!itcm_en && t < 50) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 24; i++) begin
          run += int'(itcm_en);
          if (hif.s_ready !== ((i % 4) == 3)) badr++;
          @(negedge clk);
        end
        check("b2b_en_cycles", 64'(run), 64'd24);
        check("b2b_ready_pattern", 64'(badr), 64'd0);
        check("b2b_en_after", 64'(itcm_en), 64'd0);
      end
    join
    wait_drain("b2b_drain");

    // Overflow on the 8-byte instance: two words fill ITCM, the third overflows.
    for (int k = 0; k < 8; k++) begin
      w.is_d = 1'b0;
      w.addr = 32'(k);
      w.data = b_exp[k];
      exp_qb.push_back(w);
    end
    send_b(1'b0, 32'h1122_3344, 1'b0, 1'b1);
    send_b(1'b0, 32'h5566_7788, 1'b0, 1'b1);
    send_b(1'b0, 32'h99AA_BBCC, 1'b0, 1'b0);
    check("ovf_error", 64'(b_error), 64'd1);
    check("ovf_ready", 64'(bif.s_ready), 64'd1);
    check("ovf_no_en", 64'(b_itcm_en | b_dtcm_en), 64'd0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_itcm_en || b_dtcm_en || !b_error || b_busy) bad++;
    end
    check("ovf_quiet", 64'(bad), 64'd0);
    check("ovf_bytes_written", 64'(exp_qb.size()), 64'd0);
    send_b(1'b1, 32'd0, 1'b1, 1'b0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_cpu_rst_ || b_cpu_start || b_itcm_en || b_dtcm_en) bad++;
    end
    check("err_boot_ignored", 64'(bad), 64'd0);
    check("err_ready_stays", 64'(bif.s_ready), 64'd1);

    // Random words against the model, ending with a boot on the last byte.
    do_reset();
    check("err_cleared_by_reset", 64'(b_error), 64'd0);
    for (int i = 0; i < 60; i++) begin
      hold = ($urandom_range(0, 1) == 1) || (i == 59);
      send_a(1'($urandom_range(0, 1)), $urandom, 1'b0, hold, 1'b0, 32'd0, 32'd0);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    send_a(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check_boot_a("boot_ser");
    wait_drain("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcm_boot_loader.md
# tcm_boot_loader

Boot-time loader that sits directly upstream of `cpu_top`'s TCM load ports. It accepts 32-bit program and data words from a host stream and serialises each one little-endian into byte writes on the `itcm_*` / `dtcm_*` interface. While loading, it holds the core in reset. On a host boot command it releases the core's reset and then raises `start`. It replaces the hand-driven byte sequencing used in simulation and is the synthesizable path for loading the core.

## Interface
Parameters:
- `PC_SIZE`, 32: width of `itcm_addr`; matches the core's `PC_SIZE`.
- `DATA_SIZE`, 32: width of `dtcm_addr`; matches the core's `DATA_SIZE`.
- `ITCM_BYTES`, 1024: ITCM capacity in bytes; multiple of 4, at most 2^`PC_SIZE`.
- `DTCM_BYTES`, 1024: DTCM capacity in bytes; multiple of 4, at most 2^`DATA_SIZE`.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  loader can accept a word this cycle.
- `s_data`  in  32  word to load; byte 0 is `s_data[7:0]`.
- `s_sel`  in  1  target select: 0 = ITCM, 1 = DTCM.
- `s_boot`  in  1  when set with `s_valid`, the beat is a boot command; `s_data` and `s_sel` are ignored.
- `itcm_en`, `itcm_addr` [`PC_SIZE`], `itcm_data` [8]  out  ITCM byte-write port to the core.
- `dtcm_en`, `dtcm_addr` [`DATA_SIZE`], `dtcm_data` [8]  out  DTCM byte-write port to the core.
- `cpu_rst_`  out  1  core reset, active-low.
- `cpu_start`  out  1  core start.
- `busy`  out  1  a word is being serialised.
- `error`  out  1  sticky overflow flag.

## Operation
FSM states: IDLE, SER, REL, RUN, ERR. The state resets to IDLE.

- **Handshake.** A beat transfers at a rising edge when `s_valid & s_ready` are both high.
- **`s_ready` decode.**
  - IDLE: 1.
  - SER: 1 only when `byte_idx == 3`.
  - ERR: 1 (drains the host).
  - REL, RUN: 0.
- **Data word accepted.**
  - The selected target pointer `iptr` or `dptr` is checked. If `ptr + 4 > *_BYTES`, the word is dropped, `error` is set, and the FSM enters ERR.
  - Otherwise the word is latched, `byte_idx` is set to 0, and the FSM enters SER.
- **SER, one byte per cycle.**
  - Drives `*_en = 1`, `*_addr = ptr + byte_idx`, `*_data = word[8*byte_idx +: 8]`.
  - Only the selected port is enabled; the other port's `en` stays 0.
  - After `byte_idx == 3`: the pointer advances by 4.
  - If a new beat is accepted on that same edge, SER restarts with the new word (no bubble). Otherwise the FSM returns to IDLE.
- **Pointers.** `iptr` and `dptr` are independent. Both start at 0 and never wrap; overflow goes to ERR instead.
- **Boot beat.**
  - Accepted in IDLE or in the last SER cycle; the FSM enters REL.
  - REL lasts one cycle, then RUN.
  - `cpu_rst_` is driven 1 in REL and RUN. `cpu_start` is driven 1 in RUN and held.
  - A boot with zero words loaded is legal.
- **RUN.** Terminal. All `*_en` are 0 and input is ignored.
- **ERR.** Terminal until `rst_`.
  - `cpu_rst_` stays 0 and `cpu_start` stays 0.
  - Boot beats are accepted and discarded.
- **`busy`.** Equals 1 exactly while in SER.
- **Reset mid-operation.** All state and pointers clear asynchronously. Bytes already written to the TCMs are not undone.

## Timing
- **Reset values:** `s_ready` reads 1 (IDLE decode, FSM held). All other outputs are 0: `itcm_en`, `itcm_addr`, `itcm_data`, `dtcm_en`, `dtcm_addr`, `dtcm_data`, `cpu_rst_`, `cpu_start`, `busy`, `error`.
- **Load latency:** for a word accepted at edge E, bytes 0..3 are driven in the 4 cycles following E (after edges E, E+1, E+2, E+3).
- **Throughput:** 4 cycles per word when `s_valid` is held continuously.
- **Registered outputs:** `*_en`, `*_addr`, `*_data`, `cpu_rst_` and `cpu_start` are all registered.
- **Boot accepted at edge E:** `cpu_rst_` is 1 from after E+1, `cpu_start` is 1 from after E+2. `cpu_rst_` is therefore released one cycle before `start`. No `*_en` is high after E+1.
- **Overflow beat accepted at E:** `error` is 1 from after E. No `en` pulse occurs for that word.
- **Simultaneous `s_boot` and `s_sel`:** `s_boot` wins; `s_sel` is ignored.

## Test plan
- **Single ITCM word.** After reset, send ITCM word 0x00100093. Expect `itcm_en` high for exactly 4 cycles, addresses 0,1,2,3 carrying bytes 93,00,10,00; `dtcm_en` stays 0.
- **Back-to-back ITCM words.** Send 6 ITCM words with `s_valid` held high. Expect 24 contiguous `itcm_en` cycles at addresses 0..23, with `s_ready` high on every 4th cycle.
- **DTCM words after ITCM.** After 2 ITCM words, send DTCM 0x00000001 then 0xFFFFFF03. Expect DTCM bytes 01,00,00,00,03,FF,FF,FF at addresses 0..7. A following ITCM word lands at address 8.
- **Boot.** Accept a boot beat at edge E. Expect `cpu_rst_` 0→1 after E+1 and `cpu_start` 0→1 after E+2; `s_ready` is 0 afterwards. Further valid beats produce no `en` activity.
- **Overflow.** With `ITCM_BYTES`=8, send 3 ITCM words. Expect the third to produce no `en` pulse, `error`=1, and `s_ready`=1. A subsequent boot beat leaves `cpu_rst_`=0 and `cpu_start`=0.
- **Reset mid-word.** Assert `rst_` after byte 1 of a word. Expect all outputs to reset values immediately. After reset release, the next ITCM word writes addresses 0..3.
